// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: opcode encodings, FSM state
// encoding of the iterative unit, and the datapath width.
package cpu_pkg;

    localparam int XLEN = 32;

    // Opcode values 12..15 are unused and produce a zero result.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/mul_div_iter.sv
// Iterative 32-step unsigned multiply (shift-add) and divide (restoring).
// done_o/result_o are combinational and valid on the edge that finishes step 32.
module mul_div_iter
    import cpu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            start_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    logic [0:0]      state_q, state_d;
    logic [4:0]      count_q, count_d;
    logic            is_div_q, div_zero_q;
    // x: multiplicand / dividend-quotient, y: multiplier / divisor, acc: product / remainder
    logic [XLEN-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d;
    logic [XLEN:0]   rem_sh, diff;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        rem_sh  = '0;
        diff    = '0;
        done_o  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start_i) begin
                state_d = ST_RUN;
                count_d = '0;
                x_d     = op_a_i;
                y_d     = op_b_i;
                acc_d   = '0;
            end
        end else begin
            if (is_div_q) begin
                rem_sh = {acc_q, x_q[XLEN-1]};
                diff   = rem_sh - {1'b0, y_q};
                // remainder stays below the divisor, so bit XLEN of diff is the borrow
                if (!diff[XLEN]) begin
                    acc_d = diff[XLEN-1:0];
                    x_d   = {x_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[XLEN-1:0];
                    x_d   = {x_q[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_d = acc_q + (y_q[0] ? x_q : '0);
                x_d   = x_q << 1;
                y_d   = y_q >> 1;
            end
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    assign result_o = is_div_q ? (div_zero_q ? '1 : x_d) : acc_d;
    assign busy_o   = (state_q == ST_RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            acc_q      <= '0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            if (state_q == ST_IDLE && start_i) begin
                is_div_q   <= is_div_i;
                div_zero_q <= is_div_i && (op_b_i == '0);
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: combinational ALU plus iterative MUL/DIVU, with result,
// store data and memory controls registered so they reach the memory stage together.
module execute_stage
    import cpu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            inValid,
    input  logic [3:0]      aluOp,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    input  logic [XLEN-1:0] inStoreData,
    input  logic            inWriteMemory,
    input  logic            inStoreByte,
    input  logic            inLoadByte,
    input  logic            inMemReg,
    output logic            busy,
    output logic            outValid,
    output logic [XLEN-1:0] aluResult,
    output logic [XLEN-1:0] dataStore,
    output logic            writeMemory,
    output logic            storeByte,
    output logic            loadByte,
    output logic            memReg
);

    logic            accept, is_div, iter_op, iter_done;
    logic [XLEN-1:0] iter_result, alu_res;
    logic [XLEN-1:0] result_q, store_q, p_store_q;
    logic            valid_q, wm_q, sb_q, lb_q, mr_q;
    logic            p_wm_q, p_sb_q, p_lb_q, p_mr_q;

    assign accept  = inValid && !busy;
    assign is_div  = (aluOp == OP_DIVU);
    assign iter_op = (aluOp == OP_MUL) || is_div;

    mul_div_iter u_iter (
        .clock    (clock),
        .reset    (reset),
        .start_i  (accept && iter_op),
        .is_div_i (is_div),
        .op_a_i   (operandA),
        .op_b_i   (operandB),
        .busy_o   (busy),
        .done_o   (iter_done),
        .result_o (iter_result)
    );

    always_comb begin
        alu_res = '0;
        case (aluOp)
            OP_ADD:  alu_res = operandA + operandB;
            OP_SUB:  alu_res = operandA - operandB;
            OP_AND:  alu_res = operandA & operandB;
            OP_OR:   alu_res = operandA | operandB;
            OP_XOR:  alu_res = operandA ^ operandB;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (operandA < operandB)};
            OP_SLL:  alu_res = operandA << operandB[4:0];
            OP_SRL:  alu_res = operandA >> operandB[4:0];
            OP_SRA:  alu_res = $unsigned($signed(operandA) >>> operandB[4:0]);
            default: alu_res = '0;
        endcase
    end

    // Controls of an iterative op wait in p_* until its result is ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q  <= '0;
            store_q   <= '0;
            valid_q   <= 1'b0;
            wm_q      <= 1'b0;
            sb_q      <= 1'b0;
            lb_q      <= 1'b0;
            mr_q      <= 1'b0;
            p_store_q <= '0;
            p_wm_q    <= 1'b0;
            p_sb_q    <= 1'b0;
            p_lb_q    <= 1'b0;
            p_mr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            wm_q    <= 1'b0;
            if (accept) begin
                p_store_q <= inStoreData;
                p_wm_q    <= inWriteMemory;
                p_sb_q    <= inStoreByte;
                p_lb_q    <= inLoadByte;
                p_mr_q    <= inMemReg;
            end
            if (accept && !iter_op) begin
                result_q <= alu_res;
                valid_q  <= 1'b1;
                store_q  <= inStoreData;
                wm_q     <= inWriteMemory;
                sb_q     <= inStoreByte;
                lb_q     <= inLoadByte;
                mr_q     <= inMemReg;
            end else if (iter_done) begin
                result_q <= iter_result;
                valid_q  <= 1'b1;
                store_q  <= p_store_q;
                wm_q     <= p_wm_q;
                sb_q     <= p_sb_q;
                lb_q     <= p_lb_q;
                mr_q     <= p_mr_q;
            end
        end
    end

    assign outValid    = valid_q;
    assign aluResult   = result_q;
    assign dataStore   = store_q;
    assign writeMemory = wm_q;
    assign storeByte   = sb_q;
    assign loadByte    = lb_q;
    assign memReg      = mr_q;

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the processor datapath, sitting directly upstream of the memory stage. It accepts decoded operands and an operation code and computes the ALU result that drives the memory stage's `inALU`. Single-cycle ops finish in one clock; multiply and unsigned divide run on an iterative 32-step unit behind a busy/valid handshake. The stage also registers the store data and the memory control flags so that they arrive aligned with the result.

## Interface
- No parameters; the datapath width is fixed at 32 bits.
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high.
- `inValid`  in  1  operation presented this cycle.
- `aluOp`  in  4  operation code; encodings are in the package.
- `operandA`, `operandB`  in  32  each; source operands.
- `inStoreData`  in  32  value to be stored; passed through.
- `inWriteMemory`, `inStoreByte`, `inLoadByte`, `inMemReg`  in  1 each  memory-stage controls; passed through.
- `busy`  out  1  iterative op in progress; upstream must hold.
- `outValid`  out  1  result/control valid this cycle; one-cycle pulse.
- `aluResult`  out  32  feeds memory `inALU`.
- `dataStore`  out  32  feeds memory `inDataMemory`.
- `writeMemory`, `storeByte`, `loadByte`, `memReg`  out  1 each  registered controls.

## Operation
- Ops: ADD, SUB, AND, OR, XOR, SLT (signed), SLTU, SLL, SRL, SRA, MUL (low 32 bits of unsigned product), DIVU (quotient). Shift amount is `operandB[4:0]`. All arithmetic wraps modulo 2^32, with no overflow flag.
- An op is accepted only when `inValid && !busy`. `inValid` while busy is ignored, not queued.
- FSM states:
  - IDLE: takes single-cycle ops and updates the output registers. On MUL or DIVU it loads the operands and goes to RUN with count=0.
  - RUN: performs one shift-add step (MUL) or one restoring step (DIVU) per cycle and increments count. On the edge where count==31, the final step is written to `aluResult`, `outValid` is set, and the FSM returns to IDLE.
- DIVU with `operandB`==0 gives 0xFFFFFFFF. The divisor is checked at accept, but the FSM still runs all 32 cycles so latency stays constant.
- `writeMemory` is asserted only while `outValid`=1, so a store never fires on a stale address. `storeByte`, `loadByte` and `memReg` are held with the last accepted op.
- `dataStore` and the control flags are captured at accept and presented together with the result.

## Timing
- Reset: `busy`=0, `outValid`=0, `aluResult`=0, `dataStore`=0, all control outputs 0, FSM=IDLE, count=0.
- Single-cycle op accepted at edge N: `outValid`=1 and result visible after edge N; `outValid` drops after edge N+1 unless a new op is accepted there.
- MUL/DIVU accepted at edge N:
  - `busy`=1 after edges N through N+31.
  - `busy`=0 and `outValid`=1 after edge N+32, which is 32 cycles of latency.
  - A new op may be accepted at edge N+33.
- `aluResult` holds its last value between pulses.
- Reset mid-RUN aborts the operation: no `outValid` pulse, `busy`=0 on the next cycle.
- `reset` and `inValid` asserted in the same cycle: reset wins.

## Structure
- The shared package `cpu_pkg` holds:
  - the `aluOp` localparams (ADD=0 … DIVU=10);
  - the FSM state encoding (IDLE, RUN);
  - the 32-bit width constant.
- One sub-module, `mul_div_iter`, holds the iterative multiply/divide datapath and the 5-bit step counter, with a start/done handshake.
- The combinational ALU and the output registers stay in `execute_stage`.

## Test plan
- ADD 7+5 and SUB 3-5 -> `aluResult` 12 then 0xFFFFFFFE, each with a 1-cycle `outValid` after its accept edge, and `busy` never set.
- SLT 0xFFFFFFFF vs 1 -> 1; SLTU with the same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
- MUL 1234×5678 -> 7006652; MUL 0x10000×0x10000 -> 0. For each, `busy` is high for exactly 32 cycles and `outValid` pulses at accept+32. An `inValid` ADD mid-run is ignored, with no extra `outValid`.
- DIVU 100/7 -> 14; DIVU 5/0 -> 0xFFFFFFFF, also at accept+32.
- Store: ADD 4+4 with `inWriteMemory`=1, `inStoreByte`=1, `inStoreData`=0xABCD -> `aluResult`=8, `dataStore`=0xABCD, and `writeMemory`/`storeByte` high only during the `outValid` cycle.
- `reset` asserted 10 cycles into a MUL -> `busy`=0 next cycle, all outputs 0, and no `outValid`. A following ADD 1+1 returns 2 normally.
